// File: rtl/secuenciador_activacion.sv
// Activation-stage sequencer: periodically strobes the activation logic to
// re-evaluate (Enable), debounces the returned Danger flag and issues commit
// strobes (Enable_Activacion) on confirmation, escalation and release.
module secuenciador_activacion #(
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned CONFIRM_COUNT = 3,
    parameter int unsigned HOLD_SAMPLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Run,
    input  logic       Danger,
    output logic       Enable,
    output logic       Enable_Activacion,
    output logic [1:0] Estado,
    output logic       Confirmado
);

    localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int CNF_W = $clog2(CONFIRM_COUNT + 1);
    localparam int HLD_W = $clog2(HOLD_SAMPLES + 1);

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNF_W-1:0] CNF_MAX    = CNF_W'(CONFIRM_COUNT);
    localparam logic [CNF_W-1:0] CNF_LAST   = CNF_W'(CONFIRM_COUNT - 1);
    localparam logic [HLD_W-1:0] HLD_LOAD   = HLD_W'(HOLD_SAMPLES);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MONITOR = 2'b01,
        CONFIRM = 2'b10,
        ACTIVE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNF_W-1:0] cnf_q, cnf_d;
    logic [HLD_W-1:0] hld_q, hld_d;
    logic             enable_q, enable_d;
    logic             eval_pending_q, eval_pending_d;
    logic             commit;

    // Next-state, counter and strobe decode; commit is decided in the eval
    // cycle itself because Danger is only valid in the cycle after Enable.
    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        cnf_d          = cnf_q;
        hld_d          = hld_q;
        enable_d       = 1'b0;
        eval_pending_d = 1'b0;
        commit         = 1'b0;

        if (!Run) begin
            // Disarm wins over everything: drop pending evals, clear counters.
            state_d = IDLE;
            tmr_d   = '0;
            cnf_d   = '0;
            hld_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = MONITOR;
            tmr_d   = TMR_RELOAD;
        end else begin
            // Free-running sample timer; Enable is registered, so it is
            // raised one cycle ahead of the timer reaching zero.
            if (tmr_q == '0) begin
                tmr_d = TMR_RELOAD;
            end else begin
                tmr_d = tmr_q - TMR_W'(1);
            end
            enable_d       = (tmr_q == TMR_W'(1));
            eval_pending_d = enable_q;

            if (eval_pending_q) begin
                case (state_q)
                    MONITOR: begin
                        if (Danger) begin
                            cnf_d = CNF_W'(1);
                            if (CONFIRM_COUNT == 1) begin
                                state_d = ACTIVE;
                                commit  = 1'b1;
                                hld_d   = HLD_LOAD;
                            end else begin
                                state_d = CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (Danger) begin
                            if (cnf_q >= CNF_LAST) begin
                                cnf_d   = CNF_MAX;
                                state_d = ACTIVE;
                                commit  = 1'b1;
                                hld_d   = HLD_LOAD;
                            end else begin
                                cnf_d = cnf_q + CNF_W'(1);
                            end
                        end else begin
                            state_d = MONITOR;
                            cnf_d   = '0;
                        end
                    end
                    ACTIVE: begin
                        if (Danger) begin
                            // Re-commit so weak->strong escalation propagates.
                            commit = 1'b1;
                            hld_d  = HLD_LOAD;
                        end else if (hld_q <= HLD_W'(1)) begin
                            // Hold expired: commit the off values.
                            hld_d   = '0;
                            commit  = 1'b1;
                            state_d = MONITOR;
                            cnf_d   = '0;
                        end else begin
                            hld_d = hld_q - HLD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, counters and registered strobes; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            tmr_q          <= '0;
            cnf_q          <= '0;
            hld_q          <= '0;
            enable_q       <= 1'b0;
            eval_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            cnf_q          <= cnf_d;
            hld_q          <= hld_d;
            enable_q       <= enable_d;
            eval_pending_q <= eval_pending_d;
        end
    end

    assign Enable            = enable_q;
    assign Enable_Activacion = commit;
    assign Estado            = state_q;
    assign Confirmado        = (state_q == ACTIVE);

endmodule

// File: tb/tb_secuenciador_activacion.sv
// Directed bench for secuenciador_activacion with SAMPLE_PERIOD=4,
// CONFIRM_COUNT=3, HOLD_SAMPLES=2. Cycle c is the interval after posedge c,
// where cycle 0 is the first cycle with Run=1 while IDLE.
module tb_secuenciador_activacion;

    localparam int SP = 4;
    localparam int CC = 3;
    localparam int HS = 2;

    localparam int S_IDLE = 0;
    localparam int S_MON  = 1;
    localparam int S_CNF  = 2;
    localparam int S_ACT  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       Run;
    logic       Danger;
    logic       Enable;
    logic       Enable_Activacion;
    logic [1:0] Estado;
    logic       Confirmado;

    int cyc;
    int vectors;
    int miscompares;

    secuenciador_activacion #(
        .SAMPLE_PERIOD(SP),
        .CONFIRM_COUNT(CC),
        .HOLD_SAMPLES (HS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .Run              (Run),
        .Danger           (Danger),
        .Enable           (Enable),
        .Enable_Activacion(Enable_Activacion),
        .Estado           (Estado),
        .Confirmado       (Confirmado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv();
        @(negedge clk);
        cyc++;
    endtask

    // Reset, then leave the bench at the negedge of cycle 0 with Run=1.
    task automatic start_scn();
        rst    = 1'b0;
        Run    = 1'b0;
        Danger = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_enable", 32'(Enable), 32'(0));
        chk("rst_commit", 32'(Enable_Activacion), 32'(0));
        chk("rst_estado", 32'(Estado), 32'(S_IDLE));
        chk("rst_confirmado", 32'(Confirmado), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cyc = 0;
        Run = 1'b1;
    endtask

    initial begin
        int exp_st;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b0;
        Run         = 1'b0;
        Danger      = 1'b0;

        // Idle sampling: Danger stays 0.
        start_scn();
        for (int c = 1; c <= 16; c++) begin
            adv();
            Danger = 1'b0;
            #1;
            chk("idle_enable", 32'(Enable), 32'((c % SP) == 0));
            chk("idle_commit", 32'(Enable_Activacion), 32'(0));
            chk("idle_estado", 32'(Estado), 32'(S_MON));
        end

        // Confirm, escalation re-commit, hold and release.
        start_scn();
        for (int c = 1; c <= 27; c++) begin
            adv();
            Danger = (c <= 17);
            #1;
            exp_st = (c <= 5) ? S_MON : (c <= 13) ? S_CNF : (c <= 25) ? S_ACT : S_MON;
            chk("conf_estado", 32'(Estado), 32'(exp_st));
            chk("conf_commit", 32'(Enable_Activacion), 32'(c == 13 || c == 17 || c == 25));
            chk("conf_confirmado", 32'(Confirmado), 32'(c >= 14 && c <= 25));
            chk("conf_enable", 32'(Enable), 32'((c % SP) == 0));
        end

        // Glitch rejection: Danger 1,1,0 at evals 5,9,13.
        start_scn();
        for (int c = 1; c <= 15; c++) begin
            adv();
            Danger = (c <= 9);
            #1;
            exp_st = (c <= 5) ? S_MON : (c <= 13) ? S_CNF : S_MON;
            chk("glitch_estado", 32'(Estado), 32'(exp_st));
            chk("glitch_commit", 32'(Enable_Activacion), 32'(0));
            if (c == 14) chk("glitch_cnf_cnt", 32'(dut.cnf_q), 32'(0));
        end

        // Disarm in CONFIRM at cycle 10, re-arm at cycle 13.
        start_scn();
        for (int c = 1; c <= 17; c++) begin
            adv();
            Danger = 1'b1;
            Run    = !(c >= 10 && c <= 12);
            #1;
            exp_st = (c <= 5) ? S_MON : (c <= 10) ? S_CNF : (c <= 13) ? S_IDLE : S_MON;
            chk("disarm_estado", 32'(Estado), 32'(exp_st));
            chk("disarm_enable", 32'(Enable), 32'(c == 4 || c == 8 || c == 17));
            chk("disarm_commit", 32'(Enable_Activacion), 32'(0));
            if (c == 11) chk("disarm_cnf_cnt", 32'(dut.cnf_q), 32'(0));
        end

        // Asynchronous reset while Enable is high in CONFIRM.
        start_scn();
        for (int c = 1; c <= 8; c++) begin
            adv();
            Danger = 1'b1;
        end
        #1;
        chk("pre_rst_enable", 32'(Enable), 32'(1));
        chk("pre_rst_estado", 32'(Estado), 32'(S_CNF));
        rst = 1'b0;
        #1;
        chk("async_enable", 32'(Enable), 32'(0));
        chk("async_commit", 32'(Enable_Activacion), 32'(0));
        chk("async_estado", 32'(Estado), 32'(S_IDLE));
        chk("async_confirmado", 32'(Confirmado), 32'(0));
        Run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_tmr", 32'(dut.tmr_q), 32'(0));
        chk("post_rst_cnf", 32'(dut.cnf_q), 32'(0));
        chk("post_rst_hld", 32'(dut.hld_q), 32'(0));
        chk("post_rst_eval", 32'(dut.eval_pending_q), 32'(0));

        // Asynchronous reset while the commit strobe is high.
        start_scn();
        for (int c = 1; c <= 13; c++) begin
            adv();
            Danger = 1'b1;
        end
        #1;
        chk("pre_rst_commit", 32'(Enable_Activacion), 32'(1));
        rst = 1'b0;
        #1;
        chk("async_commit2", 32'(Enable_Activacion), 32'(0));
        chk("async_estado2", 32'(Estado), 32'(S_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
